// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding and the default register window base.
package irq_pkg;
    localparam logic [63:0] BASE_DEFAULT = 64'h2100;
    localparam logic [63:0] OFF_ENABLE   = 64'h0;
    localparam logic [63:0] OFF_PENDING  = 64'h8;
    localparam logic [63:0] OFF_CLAIM    = 64'h10;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_ASSERTED = 1'b1
    } irq_state_e;
endpackage

// File: rtl/irq_controller_if.sv
// CPU register bus of the interrupt controller.
interface irq_controller_if;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;

    modport master (
        output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
        input  bus_read_data
    );
    modport slave (
        input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
        output bus_read_data
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 4
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [VEC_W-1:0] idx
);
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest index is written last.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = VEC_W'(i);
            end
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge/level capture, ENABLE/PENDING/CLAIM registers,
// fixed-priority selection and a two-state vector presentation FSM.
module irq_controller
    import irq_pkg::*;
#(
    parameter int                N_SRC     = 4,
    parameter int                VEC_W     = 4,
    parameter logic [N_SRC-1:0]  EDGE_MASK = '1,
    parameter logic [63:0]       BASE      = BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src,
    output logic [VEC_W-1:0] interrupt_vector,
    input  logic             interrupt_ack,
    output logic             interrupt_pending,
    irq_controller_if.slave  bus
);
    irq_state_e       state_q, state_d;
    logic [N_SRC-1:0] src_prev_q, src_prev_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [VEC_W-1:0] win_q, win_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic [63:0]      read_data_q, read_data_d;

    logic [N_SRC-1:0] set_vec, clr_vec, active;
    logic             any_active;
    logic [VEC_W-1:0] win_idx;
    logic             wr, rd, sel_enable, sel_pending, sel_claim;
    logic             unused_wdata;

    assign unused_wdata = ^bus.bus_write_data[63:N_SRC];

    assign active = pending_q & enable_q;

    irq_prio_enc #(.N_SRC(N_SRC), .VEC_W(VEC_W)) u_prio_enc (
        .req   (active),
        .valid (any_active),
        .idx   (win_idx)
    );

    assign sel_enable  = (bus.bus_address == BASE + OFF_ENABLE);
    assign sel_pending = (bus.bus_address == BASE + OFF_PENDING);
    assign sel_claim   = (bus.bus_address == BASE + OFF_CLAIM);
    assign wr          = bus.bus_write_enable;
    assign rd          = bus.bus_read_enable & ~bus.bus_write_enable;

    always_comb begin
        src_prev_d  = src;
        // Edge sources fire only on a 0->1 transition; level sources every high cycle.
        set_vec     = src & (~src_prev_q | ~EDGE_MASK);
        clr_vec     = '0;
        enable_d    = enable_q;
        read_data_d = read_data_q;

        if (wr && sel_enable)  enable_d = bus.bus_write_data[N_SRC-1:0];
        if (wr && sel_pending) clr_vec  = clr_vec | bus.bus_write_data[N_SRC-1:0];

        if (rd) begin
            if (sel_enable)       read_data_d = 64'(enable_q);
            else if (sel_pending) read_data_d = 64'(pending_q);
            else if (sel_claim)   read_data_d = any_active ? 64'(win_idx) + 64'd1 : 64'd0;
            else                  read_data_d = 64'd0;
            if (sel_claim && any_active) clr_vec = clr_vec | (N_SRC'(1) << win_idx);
        end

        if (state_q == ST_ASSERTED && interrupt_ack) clr_vec = clr_vec | (N_SRC'(1) << win_q);

        pending_d = (pending_q & ~clr_vec) | set_vec;

        state_d  = state_q;
        win_d    = win_q;
        vector_d = vector_q;
        case (state_q)
            ST_IDLE: begin
                if (any_active) begin
                    win_d    = win_idx;
                    vector_d = win_idx + VEC_W'(1);
                    state_d  = ST_ASSERTED;
                end
            end
            ST_ASSERTED: begin
                // Withdraw on ack, or once the presented bit is no longer pending & enabled.
                if (interrupt_ack ||
                    ((pending_d & enable_d & (N_SRC'(1) << win_q)) == '0)) begin
                    vector_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            src_prev_q  <= '0;
            enable_q    <= '0;
            pending_q   <= '0;
            win_q       <= '0;
            vector_q    <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            src_prev_q  <= src_prev_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            win_q       <= win_d;
            vector_q    <= vector_d;
            read_data_q <= read_data_d;
        end
    end

    assign interrupt_vector  = vector_q;
    assign interrupt_pending = |active;
    assign bus.bus_read_data = read_data_q;
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural model of the controller's register and presentation rules.
module tb_irq_controller;
    import irq_pkg::*;

    localparam int          N  = 4;
    localparam int          VW = 4;
    localparam logic [N-1:0] EM = 4'b0111;
    localparam logic [63:0] B  = BASE_DEFAULT;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  src = '0;
    logic          ack = 1'b0;
    logic [VW-1:0] vec;
    logic          ipend;

    irq_controller_if bus ();

    irq_controller #(.N_SRC(N), .VEC_W(VW), .EDGE_MASK(EM), .BASE(B)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .src               (src),
        .interrupt_vector  (vec),
        .interrupt_ack     (ack),
        .interrupt_pending (ipend),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: presented vector number (0 = nothing shown), per-source bits.
    bit          m_en[N];
    bit          m_pend[N];
    bit          m_prev[N];
    int          m_pres;
    logic [63:0] m_rd;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
        end
        m_pres = 0;
        m_rd   = 64'd0;
    endtask

    function automatic int m_winner();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i]) return i;
        return -1;
    endfunction

    function automatic logic m_ipend();
        return (m_winner() >= 0);
    endfunction

    task automatic model_step();
        int   w;
        bit   set_b[N], clr_b[N], nen[N], npend[N];
        logic we, re;
        logic [63:0] a, wd, val;
        w  = m_winner();
        we = bus.bus_write_enable;
        re = bus.bus_read_enable && !we;
        a  = bus.bus_address;
        wd = bus.bus_write_data;
        for (int i = 0; i < N; i++) begin
            set_b[i] = EM[i] ? (src[i] && !m_prev[i]) : src[i];
            clr_b[i] = 0;
            nen[i]   = m_en[i];
        end
        if (we && a == B)     for (int i = 0; i < N; i++) nen[i] = wd[i];
        if (we && a == B + 8) for (int i = 0; i < N; i++) clr_b[i] = wd[i];
        if (re) begin
            val = 64'd0;
            if (a == B)          for (int i = 0; i < N; i++) val[i] = m_en[i];
            else if (a == B + 8) for (int i = 0; i < N; i++) val[i] = m_pend[i];
            else if (a == B + 16) begin
                val = 64'(w + 1);
                if (w >= 0) clr_b[w] = 1;
            end
            m_rd = val;
        end
        if (m_pres != 0 && ack) clr_b[m_pres - 1] = 1;
        for (int i = 0; i < N; i++) npend[i] = set_b[i] || (m_pend[i] && !clr_b[i]);
        if (m_pres == 0) begin
            if (w >= 0) m_pres = w + 1;
        end else if (ack || !(npend[m_pres - 1] && nen[m_pres - 1])) begin
            m_pres = 0;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = npend[i];
            m_en[i]   = nen[i];
            m_prev[i] = src[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step(); else model_reset();
        #1;
        chk("vector", 64'(vec), 64'(m_pres));
        chk("irq_pending", 64'(ipend), 64'(m_ipend()));
        chk("read_data", bus.bus_read_data, m_rd);
    endtask

    task automatic bus_wr(input logic [63:0] addr, input logic [63:0] data);
        bus.bus_address = addr; bus.bus_write_data = data; bus.bus_write_enable = 1'b1;
        tick();
        bus.bus_write_enable = 1'b0;
    endtask

    task automatic bus_rd(input logic [63:0] addr);
        bus.bus_address = addr; bus.bus_read_enable = 1'b1;
        tick();
        bus.bus_read_enable = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] s);
        src = s; tick(); src = '0; tick();
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    initial begin
        logic [63:0] addrs[6];
        bus.bus_address = '0; bus.bus_write_data = '0;
        bus.bus_write_enable = 1'b0; bus.bus_read_enable = 1'b0;
        model_reset();
        #1;
        chk("reset_vector", 64'(vec), 64'd0);
        chk("reset_ipend", 64'(ipend), 64'd0);
        chk("reset_rdata", bus.bus_read_data, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Enabled edge source held 3 cycles: one event, vector 3 two cycles after.
        bus_wr(B, 64'hF);
        src = 4'b0100; tick(); tick();
        chk("s1_vec3", 64'(vec), 64'd3);
        tick(); src = '0;
        bus_rd(B + 8);
        chk("s1_pending", bus.bus_read_data, 64'h4);
        do_ack();
        chk("s1_ack_vec", 64'(vec), 64'd0);
        bus_rd(B + 8);
        chk("s1_one_event", bus.bus_read_data, 64'h0);
        $display("scenario single-edge done");

        // Two simultaneous sources served in priority order.
        pulse(4'b1010);
        chk("s2_vec2", 64'(vec), 64'd2);
        do_ack();
        chk("s2_gap", 64'(vec), 64'd0);
        tick();
        chk("s2_vec4", 64'(vec), 64'd4);
        do_ack();
        chk("s2_done_vec", 64'(vec), 64'd0);
        chk("s2_done_ipend", 64'(ipend), 64'd0);
        $display("scenario priority-pair done");

        // No preemption of a presented vector.
        pulse(4'b1000);
        pulse(4'b0001);
        chk("s3_hold4", 64'(vec), 64'd4);
        do_ack();
        tick();
        chk("s3_vec1", 64'(vec), 64'd1);
        do_ack();
        tick();
        $display("scenario no-preempt done");

        // Ack coinciding with a fresh edge of the same source.
        pulse(4'b0100);
        chk("s4_vec3", 64'(vec), 64'd3);
        src = 4'b0100; ack = 1'b1; tick(); ack = 1'b0; src = '0;
        chk("s4_gap", 64'(vec), 64'd0);
        bus_rd(B + 8);
        chk("s4_pend_kept", bus.bus_read_data, 64'h4);
        chk("s4_represent", 64'(vec), 64'd3);
        do_ack();
        tick();
        $display("scenario ack-vs-set done");

        // Disabled source stays pending; enabling presents it; claim withdraws it.
        bus_wr(B, 64'h0);
        pulse(4'b0001);
        bus_rd(B + 8);
        chk("s5_pend1", bus.bus_read_data, 64'h1);
        chk("s5_vec0", 64'(vec), 64'd0);
        bus_wr(B, 64'h1);
        tick();
        chk("s5_vec1", 64'(vec), 64'd1);
        bus_rd(B + 16);
        chk("s5_claim", bus.bus_read_data, 64'd1);
        chk("s5_claim_vec", 64'(vec), 64'd0);
        bus_rd(B + 8);
        chk("s5_pend0", bus.bus_read_data, 64'h0);
        $display("scenario enable-claim done");

        // Asynchronous reset while a vector is presented.
        bus_wr(B, 64'hF);
        pulse(4'b0010);
        chk("s6_vec2", 64'(vec), 64'd2);
        @(posedge clk); #3;
        reset_n = 1'b0; model_reset();
        #1;
        chk("s6_rst_vec", 64'(vec), 64'd0);
        chk("s6_rst_ipend", 64'(ipend), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        bus_rd(B);      chk("s6_en0", bus.bus_read_data, 64'd0);
        bus_rd(B + 8);  chk("s6_pend0", bus.bus_read_data, 64'd0);
        bus_rd(B + 16); chk("s6_claim0", bus.bus_read_data, 64'd0);
        $display("scenario reset done");

        // Random traffic against the model.
        addrs[0] = B; addrs[1] = B + 8; addrs[2] = B + 16;
        addrs[3] = B + 24; addrs[4] = B + 4; addrs[5] = 64'h0;
        for (int c = 0; c < 2000; c++) begin
            int op;
            src = (($urandom % 3) == 0) ? N'($urandom) : '0;
            ack = (($urandom % 4) == 0);
            op  = int'($urandom % 8);
            bus.bus_address      = addrs[$urandom % 6];
            bus.bus_write_data   = {$urandom, $urandom};
            bus.bus_write_enable = (op == 0 || op == 2);
            bus.bus_read_enable  = (op == 1 || op == 2 || op == 3);
            tick();
        end
        bus.bus_write_enable = 1'b0; bus.bus_read_enable = 1'b0;
        src = '0; ack = 1'b0;
        $display("random phase done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4: the number of interrupt sources, legal range 1..15.
REQ-002 The block SHALL have parameter VEC_W, default 4: the vector width, with 2**VEC_W > N_SRC.
REQ-003 The block SHALL have parameter EDGE_MASK, width N_SRC, default all-ones: bit i=1 makes source i rising-edge sensitive; bit i=0 makes it level sensitive.
REQ-004 The block SHALL have parameter BASE, 64-bit, default 64'h2100: the register window base address.
REQ-005 Port clk, input, 1: single clock; all logic is posedge clk.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port src, input, N_SRC: raw interrupt sources, already synchronous to clk.
REQ-008 Port interrupt_vector, output, VEC_W: index+1 of the presented source; 0 = none.
REQ-009 Port interrupt_ack, input, 1: CPU acknowledge of the presented vector.
REQ-010 Port interrupt_pending, output, 1: OR of (pending & enable).
REQ-011 Port bus_address, input, 64: CPU bus address.
REQ-012 Port bus_write_data, input, 64: CPU bus write data.
REQ-013 Port bus_write_enable, input, 1: CPU bus write strobe.
REQ-014 Port bus_read_enable, input, 1: CPU bus read strobe.
REQ-015 Port bus_read_data, output, 64: registered read data.

Function
REQ-016 Register map SHALL be: BASE+0x0 ENABLE (R/W), BASE+0x8 PENDING (R, write-1-to-clear), BASE+0x10 CLAIM (R only; writes ignored); other addresses are not selected.
REQ-017 Edge sources SHALL set pending[i] on cycle t+1 when src[i] is 1 at t and was 0 at t-1 (one delay register per source).
REQ-018 Level sources SHALL set pending[i] every cycle src[i]=1.
REQ-019 A set event SHALL win over a clear (W1C, ack or claim) on the same bit in the same cycle.
REQ-020 Selection SHALL be fixed priority: the lowest index with pending & enable wins.
REQ-021 The FSM SHALL have states IDLE and ASSERTED.
REQ-022 In IDLE with any pending & enable, the block SHALL latch the winner, drive interrupt_vector=winner+1 from the next cycle and enter ASSERTED.
REQ-023 In ASSERTED, the vector SHALL be held stable with no preemption by higher-priority arrivals.
REQ-024 In ASSERTED with interrupt_ack=1, the block SHALL clear pending[winner], drive vector=0 next cycle and return to IDLE; at least one zero cycle separates consecutive vectors.
REQ-025 In ASSERTED, if the presented bit is cleared by W1C, disabled via ENABLE or claimed, the vector SHALL drop to 0 next cycle and the FSM returns to IDLE.
REQ-026 interrupt_ack in IDLE SHALL be ignored.
REQ-027 Reads SHALL have 1-cycle latency: bus_read_data is valid the cycle after bus_read_enable and holds until the next read.
REQ-028 A read to an unmapped address SHALL return 0.
REQ-029 A CLAIM read SHALL return the current winner+1 (or 0 if none) and clear that pending bit in the same cycle.
REQ-030 If bus_write_enable and bus_read_enable are both asserted, the write SHALL be performed and the read ignored.
REQ-031 ENABLE and PENDING reads SHALL be zero-extended to 64 bits; write bits above N_SRC SHALL be ignored.

Reset
REQ-032 While reset_n=0, the block SHALL hold ENABLE=0, PENDING=0, edge delay registers=0, FSM=IDLE, interrupt_vector=0, interrupt_pending=0 and bus_read_data=0, asynchronously.
REQ-033 A reset asserted mid-ASSERTED SHALL drop the vector immediately and lose all pending events.

Structure
REQ-034 Register offsets, FSM state encoding and the BASE default SHALL live in shared package irq_pkg (header.vh defines for Verilog builds).
REQ-035 The fixed-priority encoder SHALL be a sub-module, irq_prio_enc, parameterised by N_SRC and VEC_W.

Verification
REQ-036 ENABLE=0xF; pulse src[2] high for 3 cycles -> vector=3 after 2 cycles; PENDING reads 0x4; exactly one event is recorded.
REQ-037 src[1] and src[3] rise together -> vector=2; ack -> one cycle of 0, then vector=4; second ack -> vector=0 and interrupt_pending=0.
REQ-038 Vector=4 presented, then src[0] rises -> vector stays 4 until ack, then becomes 1.
REQ-039 Ack on the same cycle as a new src[2] edge while vector=3 -> PENDING bit 2 remains set and vector=3 re-presents after a 0 cycle.
REQ-040 ENABLE=0x0, src[0] edge -> PENDING=0x1, vector stays 0; write ENABLE=0x1 -> vector=1; CLAIM read -> returns 1, vector drops, PENDING=0.
REQ-041 Assert reset_n=0 while vector=2 -> vector=0 within the same cycle; after release all registers read 0.
